// File: rtl/irrigation_pkg.sv
// Shared types and sizing helpers for the irrigation pump controller.
//   state_e        : FSM state encoding (also driven out on state_o)
//   timer_width()  : bits needed by the shared WATER/SOAK timer
//   WC_W / WC_MAX  : water_count width and saturation value
package irrigation_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WATER = 2'd1,
    S_SOAK  = 2'd2,
    S_FAULT = 2'd3
  } state_e;

  localparam int WC_W = 8;
  localparam logic [WC_W-1:0] WC_MAX = {WC_W{1'b1}};

  // One timer serves both phases, so it must hold the larger terminal count.
  function automatic int timer_width(input int max_on, input int soak);
    int m;
    m = (max_on > soak) ? max_on : soak;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/irrigation_pump_ctrl_sensor_debounce.sv
// Moisture sensor front end: 2-flop synchroniser on the raw, active-low
// collector pin followed by a consecutive-sample debounce.
//   clk, rst      : system clock, synchronous active-high reset
//   sensor_col_n  : raw collector (0 = wet, 1 = dry), asynchronous
//   sensor_wet    : debounced wet flag; resets to 1 so the pump stays off
//                   until dryness has been proven
module sensor_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_col_n,
  output logic sensor_wet
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  // sync_pipe[0] is the metastability catcher, sync_pipe[1] is safe to use.
  logic [1:0]    sync_pipe;
  logic [CW-1:0] cnt;
  logic          synced_wet;

  assign synced_wet = ~sync_pipe[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_pipe  <= 2'b00;
      cnt        <= '0;
      sensor_wet <= 1'b1;
    end else begin
      sync_pipe <= {sync_pipe[0], sensor_col_n};
      if (synced_wet != sensor_wet) begin
        // The Nth consecutive disagreeing sample flips the output.
        if (cnt == CNT_LAST) begin
          sensor_wet <= synced_wet;
          cnt        <= '0;
        end else begin
          cnt <= cnt + CNT_ONE;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/irrigation_pump_ctrl.sv
// Closed-loop irrigation controller. Waters while the soil is dry, then
// enforces a soak pause; a watering run that exceeds MAX_ON_CYCLES latches
// FAULT until fault_clr.
//   clk, rst      : system clock, synchronous active-high reset
//   enable        : level, 1 = automatic watering allowed
//   sensor_col_n  : raw sensor collector pin (0 = wet), asynchronous
//   fault_clr     : single-cycle pulse, only acted on in FAULT
//   pump_on       : pump drive (state == WATER)
//   sensor_wet    : debounced wet flag for the board LED
//   fault         : state == FAULT
//   state_o       : current state encoding
//   water_count   : completed waterings, saturating
module irrigation_pump_ctrl
  import irrigation_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int MAX_ON_CYCLES   = 250000000,
  parameter int SOAK_CYCLES     = 125000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            sensor_col_n,
  input  logic            fault_clr,
  output logic            pump_on,
  output logic            sensor_wet,
  output logic            fault,
  output logic [1:0]      state_o,
  output logic [WC_W-1:0] water_count
);

  localparam int TW = timer_width(MAX_ON_CYCLES, SOAK_CYCLES);
  localparam logic [TW-1:0] ON_LAST   = TW'(MAX_ON_CYCLES - 1);
  localparam logic [TW-1:0] SOAK_LAST = TW'(SOAK_CYCLES - 1);
  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
  localparam logic [WC_W-1:0] WC_ONE  = WC_W'(1);

  state_e          state;
  logic [TW-1:0]   timer;

  sensor_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk          (clk),
    .rst          (rst),
    .sensor_col_n (sensor_col_n),
    .sensor_wet   (sensor_wet)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      timer       <= '0;
      water_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (enable && !sensor_wet) state <= S_WATER;
        end
        S_WATER: begin
          // A normal stop wins over the timeout on the same cycle.
          if (!enable || sensor_wet) begin
            state <= S_SOAK;
            timer <= '0;
            if (water_count != WC_MAX) water_count <= water_count + WC_ONE;
          end else if (timer == ON_LAST) begin
            state <= S_FAULT;
            timer <= '0;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        S_SOAK: begin
          // Runs to completion regardless of enable or the sensor.
          if (timer == SOAK_LAST) begin
            state <= S_IDLE;
            timer <= '0;
          end else begin
            timer <= timer + TMR_ONE;
          end
        end
        default: begin
          timer <= '0;
          if (fault_clr) state <= S_IDLE;
        end
      endcase
    end
  end

  assign pump_on = (state == S_WATER);
  assign fault   = (state == S_FAULT);
  assign state_o = state;

endmodule

// File: tb/tb_irrigation_pump_ctrl.sv
// Directed bench for irrigation_pump_ctrl with shrunk timing
// (DEBOUNCE=4, MAX_ON=20, SOAK=10). Cycle numbers below count rising
// edges after the reset release; outputs are sampled 1 time unit after
// each edge and inputs are changed at the same point.
module tb_irrigation_pump_ctrl;

  logic       clk = 1'b0;
  logic       rst, enable, sensor_col_n, fault_clr;
  logic       pump_on, sensor_wet, fault;
  logic [1:0] state_o;
  logic [7:0] water_count;

  int n_tests = 0;
  int n_fail  = 0;

  irrigation_pump_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .MAX_ON_CYCLES   (20),
    .SOAK_CYCLES     (10)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .sensor_col_n (sensor_col_n),
    .fault_clr    (fault_clr),
    .pump_on      (pump_on),
    .sensor_wet   (sensor_wet),
    .fault        (fault),
    .state_o      (state_o),
    .water_count  (water_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; sensor_col_n = 1'b1; fault_clr = 1'b0;
    repeat (3) tick();
    n_tests++; if (pump_on !== 1'b0) begin n_fail++; $display("FAIL reset_pump: got %b exp 0", pump_on); end
    n_tests++; if (sensor_wet !== 1'b1) begin n_fail++; $display("FAIL reset_wet: got %b exp 1", sensor_wet); end
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b exp 0", fault); end
    n_tests++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d exp 0", state_o); end
    n_tests++; if (water_count !== 8'd0) begin n_fail++; $display("FAIL reset_wc: got %0d exp 0", water_count); end
  endtask

  // Dry from release: wet drops at 6, pump at 7; pin goes wet after edge 12,
  // wet rises at 18, SOAK 19..28, IDLE from 29.
  task automatic test_normal_cycle();
    logic       e_wet, e_pump;
    logic [1:0] e_st;
    logic [7:0] e_wc;
    rst = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      e_wet  = (c < 6 || c >= 18);
      e_pump = (c >= 7 && c <= 18);
      e_st   = (c < 7) ? 2'd0 : (c <= 18) ? 2'd1 : (c <= 28) ? 2'd2 : 2'd0;
      e_wc   = (c >= 19) ? 8'd1 : 8'd0;
      n_tests++; if (sensor_wet !== e_wet) begin n_fail++; $display("FAIL normal_wet c=%0d: got %b exp %b", c, sensor_wet, e_wet); end
      n_tests++; if (pump_on !== e_pump) begin n_fail++; $display("FAIL normal_pump c=%0d: got %b exp %b", c, pump_on, e_pump); end
      n_tests++; if (state_o !== e_st) begin n_fail++; $display("FAIL normal_state c=%0d: got %0d exp %0d", c, state_o, e_st); end
      n_tests++; if (water_count !== e_wc) begin n_fail++; $display("FAIL normal_wc c=%0d: got %0d exp %0d", c, water_count, e_wc); end
      if (c == 12) sensor_col_n = 1'b0;
    end
  endtask

  // From IDLE/wet: go dry, pump must start 7 cycles later, then a 3-cycle
  // wet glitch (one short of the debounce count) must be ignored.
  task automatic test_glitch();
    int lat;
    lat = 0;
    sensor_col_n = 1'b1;
    while (pump_on !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    n_tests++; if (lat != 7) begin n_fail++; $display("FAIL glitch_start_latency: got %0d exp 7", lat); end
    sensor_col_n = 1'b0;
    repeat (3) tick();
    sensor_col_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i > 0) tick();
      n_tests++; if (sensor_wet !== 1'b0) begin n_fail++; $display("FAIL glitch_wet i=%0d: got %b exp 0", i, sensor_wet); end
      n_tests++; if (pump_on !== 1'b1) begin n_fail++; $display("FAIL glitch_pump i=%0d: got %b exp 1", i, pump_on); end
    end
  endtask

  // Restart dry: pump on 7..26 (20 cycles), FAULT from 27 and held.
  task automatic test_timeout_and_clear();
    int  on_cnt;
    logic e_pump;
    on_cnt = 0;
    rst = 1'b1; tick(); rst = 1'b0;
    for (int c = 1; c <= 27; c++) begin
      tick();
      if (pump_on === 1'b1) on_cnt++;
      e_pump = (c >= 7 && c <= 26);
      n_tests++; if (pump_on !== e_pump) begin n_fail++; $display("FAIL timeout_pump c=%0d: got %b exp %b", c, pump_on, e_pump); end
    end
    n_tests++; if (on_cnt != 20) begin n_fail++; $display("FAIL timeout_on_cycles: got %0d exp 20", on_cnt); end
    n_tests++; if (fault !== 1'b1) begin n_fail++; $display("FAIL timeout_fault: got %b exp 1", fault); end
    n_tests++; if (state_o !== 2'd3) begin n_fail++; $display("FAIL timeout_state: got %0d exp 3", state_o); end
    n_tests++; if (water_count !== 8'd0) begin n_fail++; $display("FAIL timeout_wc: got %0d exp 0", water_count); end
    for (int i = 0; i < 50; i++) begin
      tick();
      n_tests++;
      if (state_o !== 2'd3 || fault !== 1'b1 || pump_on !== 1'b0) begin
        n_fail++;
        $display("FAIL fault_hold i=%0d: got state=%0d fault=%b pump=%b exp 3/1/0", i, state_o, fault, pump_on);
      end
    end
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    n_tests++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL clear_state: got %0d exp 0", state_o); end
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL clear_fault: got %b exp 0", fault); end
    tick();
    n_tests++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL rewater_state: got %0d exp 1", state_o); end
    n_tests++; if (pump_on !== 1'b1) begin n_fail++; $display("FAIL rewater_pump: got %b exp 1", pump_on); end
  endtask

  // Entered on pump cycle 1. fault_clr in WATER is ignored; disable on the
  // 20th cycle goes to SOAK, which runs its full 10 cycles.
  task automatic test_priority();
    fault_clr = 1'b1; tick(); fault_clr = 1'b0;
    n_tests++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL clr_ignored_state: got %0d exp 1", state_o); end
    for (int n = 3; n <= 20; n++) begin
      tick();
      n_tests++; if (pump_on !== 1'b1) begin n_fail++; $display("FAIL prio_pump n=%0d: got %b exp 1", n, pump_on); end
    end
    enable = 1'b0;
    tick();
    n_tests++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL prio_state: got %0d exp 2", state_o); end
    n_tests++; if (fault !== 1'b0) begin n_fail++; $display("FAIL prio_fault: got %b exp 0", fault); end
    n_tests++; if (water_count !== 8'd1) begin n_fail++; $display("FAIL prio_wc: got %0d exp 1", water_count); end
    for (int s = 2; s <= 10; s++) begin
      tick();
      n_tests++; if (state_o !== 2'd2) begin n_fail++; $display("FAIL soak_len s=%0d: got %0d exp 2", s, state_o); end
      if (s == 5) enable = 1'b1;
    end
    tick();
    n_tests++; if (state_o !== 2'd0) begin n_fail++; $display("FAIL soak_end: got %0d exp 0", state_o); end
    tick();
    n_tests++; if (state_o !== 2'd1) begin n_fail++; $display("FAIL soak_rewater: got %0d exp 1", state_o); end
    n_tests++; if (water_count !== 8'd1) begin n_fail++; $display("FAIL soak_wc: got %0d exp 1", water_count); end
  endtask

  task automatic test_reset_mid_water();
    logic e_pump, e_wet;
    tick(); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    n_tests++; if (pump_on !== 1'b0) begin n_fail++; $display("FAIL midrst_pump: got %b exp 0", pump_on); end
    n_tests++; if (water_count !== 8'd0) begin n_fail++; $display("FAIL midrst_wc: got %0d exp 0", water_count); end
    n_tests++; if (sensor_wet !== 1'b1) begin n_fail++; $display("FAIL midrst_wet: got %b exp 1", sensor_wet); end
    for (int c = 1; c <= 7; c++) begin
      tick();
      e_pump = (c == 7);
      e_wet  = (c < 6);
      n_tests++; if (pump_on !== e_pump) begin n_fail++; $display("FAIL midrst_pump c=%0d: got %b exp %b", c, pump_on, e_pump); end
      n_tests++; if (sensor_wet !== e_wet) begin n_fail++; $display("FAIL midrst_wet c=%0d: got %b exp %b", c, sensor_wet, e_wet); end
    end
  endtask

  initial begin
    test_reset();
    test_normal_cycle();
    test_glitch();
    test_timeout_and_clear();
    test_priority();
    test_reset_mid_water();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
